// File: rtl/go_finish_initiator.sv
// Initiator side of the go/finish job handshake: launches a batch of jobs to a
// worker, waits for each finish, spaces jobs by a fixed gap, reports completion.
module go_finish_initiator #(
  parameter int CNT_W          = 4,
  parameter int TIMEOUT_CYCLES = 32,
  parameter int GAP_CYCLES     = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] num_jobs,
  input  logic             finish,
  output logic             go,
  output logic             busy,
  output logic             done,
  output logic             timeout_err,
  output logic [CNT_W-1:0] jobs_done,
  output logic [1:0]       state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    GAP   = 2'd3
  } state_t;

  localparam int TMR_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int GAP_W = $clog2(GAP_CYCLES + 2);

  state_t             st;
  logic [CNT_W-1:0]   target;
  logic [TMR_W-1:0]   timer;
  logic [GAP_W-1:0]   gap_cnt;
  logic [CNT_W-1:0]   next_count;

  assign next_count = jobs_done + CNT_W'(1);
  assign state      = st;

  // NOTE: state and outputs use non-blocking assignments only, so every branch
  // below reads the values from before the clock edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      // NOTE: every register, internal counters included, is reset so a
      // mid-batch reset leaves no stale job state behind.
      st          <= IDLE;
      go          <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      timeout_err <= 1'b0;
      jobs_done   <= '0;
      target      <= '0;
      timer       <= '0;
      gap_cnt     <= '0;
    end else begin
      done <= 1'b0;
      go   <= 1'b0;
      case (st)
        IDLE: begin
          if (start) begin
            if (num_jobs != '0) begin
              target      <= num_jobs;
              jobs_done   <= '0;
              timeout_err <= 1'b0;
              st          <= ISSUE;
              go          <= 1'b1;
              busy        <= 1'b1;
            end else begin
              done      <= 1'b1;
              jobs_done <= '0;
            end
          end
        end

        ISSUE: begin
          timer <= '0;
          st    <= WAIT;
        end

        WAIT: begin
          // A finish in the last allowed cycle beats the timeout.
          if (finish) begin
            jobs_done <= next_count;
            if (next_count == target) begin
              st   <= IDLE;
              busy <= 1'b0;
              done <= 1'b1;
            end else if (GAP_CYCLES == 0) begin
              st <= ISSUE;
              go <= 1'b1;
            end else begin
              st      <= GAP;
              gap_cnt <= '0;
            end
          end else if (timer == TMR_W'(TIMEOUT_CYCLES - 1)) begin
            timeout_err <= 1'b1;
            st          <= IDLE;
            busy        <= 1'b0;
          end else begin
            timer <= timer + TMR_W'(1);
          end
        end

        GAP: begin
          // Held GAP_CYCLES+1 cycles: go period is 3+GAP_CYCLES when the
          // worker finishes in its first WAIT cycle.
          if (gap_cnt == GAP_W'(GAP_CYCLES)) begin
            st <= ISSUE;
            go <= 1'b1;
          end else begin
            gap_cnt <= gap_cnt + GAP_W'(1);
          end
        end

        default: begin
          st   <= IDLE;
          busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_go_finish_initiator.sv
// Randomised bench for go_finish_initiator: a transaction-level model predicts
// go/done/timeout events with cycle stamps; a monitor pops and compares them.
module tb_go_finish_initiator;

  localparam int CNT_W   = 4;
  localparam int TIMEOUT = 32;
  localparam int GAP     = 2;

  typedef enum int {EV_GO = 0, EV_DONE = 1, EV_TOUT = 2} ev_kind_e;
  typedef struct {
    ev_kind_e kind;
    int       cyc;
    int       jobs;
  } ev_t;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic [CNT_W-1:0] num_jobs;
  logic             finish;
  logic             go;
  logic             busy;
  logic             done;
  logic             timeout_err;
  logic [CNT_W-1:0] jobs_done;
  logic [1:0]       state;

  int  checks   = 0;
  int  failures = 0;
  int  cyc      = 0;
  bit  prev_tout = 1'b0;

  ev_t exp_q[$];
  int  dly_q[$];
  bit  stray_q[$];
  int  dl[$];
  bit  sl[$];

  go_finish_initiator #(
    .CNT_W(CNT_W),
    .TIMEOUT_CYCLES(TIMEOUT),
    .GAP_CYCLES(GAP)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .num_jobs(num_jobs),
    .finish(finish),
    .go(go),
    .busy(busy),
    .done(done),
    .timeout_err(timeout_err),
    .jobs_done(jobs_done),
    .state(state)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Job timeline from the handshake rules: a job with delay d (finish held in
  // cycle go+d) completes at go+d+1; the next go follows at go+d+GAP+2.
  // d==0 or d>TIMEOUT means the worker never answers in time.
  task automatic push_batch(input int n, input int s);
    int g;
    int jobs;
    int d;
    g    = s;
    jobs = 0;
    if (n == 0) begin
      exp_q.push_back('{EV_DONE, s, 0});
      return;
    end
    for (int k = 0; k < n; k++) begin
      exp_q.push_back('{EV_GO, g, jobs});
      d = (k < dl.size()) ? dl[k] : 0;
      if (d == 0 || d > TIMEOUT) begin
        exp_q.push_back('{EV_TOUT, g + TIMEOUT + 1, jobs});
        return;
      end
      jobs++;
      if (jobs == n) begin
        exp_q.push_back('{EV_DONE, g + d + 1, n});
        return;
      end
      g = g + d + GAP + 2;
    end
  endtask

  task automatic expect_ev(input ev_kind_e kind);
    ev_t e;
    check("event_expected", (exp_q.size() > 0) ? 1 : 0, 1);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("ev_kind", int'(kind), int'(e.kind));
      check("ev_cycle", cyc, e.cyc);
      check("ev_jobs_done", int'(jobs_done), e.jobs);
      case (kind)
        EV_GO: begin
          check("go_busy", int'(busy), 1);
          check("go_timeout_clear", int'(timeout_err), 0);
        end
        default: begin
          check("end_busy", int'(busy), 0);
          check("end_state", int'(state), 0);
        end
      endcase
    end
  endtask

  // Monitor: samples on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (go === 1'b1)   expect_ev(EV_GO);
      if (done === 1'b1) expect_ev(EV_DONE);
      if (timeout_err === 1'b1 && !prev_tout) expect_ev(EV_TOUT);
    end
    prev_tout = (timeout_err === 1'b1);
  end

  // Worker model: answers each go after the delay queued for that job,
  // optionally holding finish one extra (stray) cycle.
  initial begin
    int  d;
    bit  s;
    finish = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && go === 1'b1 && dly_q.size() > 0) begin
        d = dly_q.pop_front();
        s = stray_q.pop_front();
        if (d != 0) begin
          repeat (d) @(negedge clk);
          finish = 1'b1;
          if (s) @(negedge clk);
          @(negedge clk);
          finish = 1'b0;
        end
      end
    end
  end

  task automatic wait_drain(input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("events_drained", exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_go"}, int'(go), 0);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_done"}, int'(done), 0);
    check({tag, "_timeout_err"}, int'(timeout_err), 0);
    check({tag, "_jobs_done"}, int'(jobs_done), 0);
    check({tag, "_state"}, int'(state), 0);
  endtask

  // Issues one batch using the delays in dl/sl; optionally pokes start while
  // the first job is in WAIT, which must be ignored.
  task automatic run_batch(input int n, input bit inject);
    int budget;
    @(negedge clk);
    start    = 1'b1;
    num_jobs = CNT_W'(n);
    push_batch(n, cyc + 1);
    foreach (dl[i]) begin
      dly_q.push_back(dl[i]);
      stray_q.push_back((i < sl.size()) ? sl[i] : 1'b0);
    end
    @(negedge clk);
    start    = 1'b0;
    num_jobs = CNT_W'($urandom_range(0, 15));
    if (inject && n > 0) begin
      @(negedge clk);
      start    = 1'b1;
      num_jobs = CNT_W'($urandom_range(1, 15));
      @(negedge clk);
      start = 1'b0;
    end
    budget = (n + 1) * (TIMEOUT + GAP + 8);
    wait_drain(budget);
    repeat (4) @(negedge clk);
    dly_q.delete();
    stray_q.delete();
  endtask

  initial begin
    rst_n    = 1'b0;
    start    = 1'b1;
    num_jobs = 4'd3;

    // Reset hold with start asserted.
    repeat (2) begin
      @(negedge clk);
      check_zero("reset_hold");
    end
    rst_n = 1'b1;
    start = 1'b0;
    repeat (2) begin
      @(negedge clk);
      check("post_reset_go", int'(go), 0);
    end

    // Single job, finish three cycles after go.
    dl = {3}; sl = {0};
    run_batch(1, 1'b0);

    // Three jobs finishing in the first WAIT cycle: go every 5 cycles.
    dl = {1, 1, 1}; sl = {0, 0, 0};
    run_batch(3, 1'b0);

    // Worker never answers: timeout, then a fresh start clears it.
    dl = {0}; sl = {0};
    run_batch(2, 1'b0);
    check("timeout_sticky", int'(timeout_err), 1);
    dl = {2}; sl = {0};
    run_batch(1, 1'b0);
    check("timeout_cleared", int'(timeout_err), 0);

    // Empty batch, finish on the timeout cycle, stray finishes, start in WAIT.
    dl = {}; sl = {};
    run_batch(0, 1'b0);
    dl = {TIMEOUT, 1}; sl = {1, 1};
    run_batch(2, 1'b1);

    // Reset during WAIT of job 2 of 4.
    dl = {2, 0}; sl = {0, 0};
    @(negedge clk);
    start    = 1'b1;
    num_jobs = 4'd4;
    push_batch(4, cyc + 1);
    void'(exp_q.pop_back());
    foreach (dl[i]) begin
      dly_q.push_back(dl[i]);
      stray_q.push_back(1'b0);
    end
    @(negedge clk);
    start = 1'b0;
    wait_drain(100);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check_zero("mid_reset");
    rst_n = 1'b1;
    @(negedge clk);
    check("mid_reset_after_go", int'(go), 0);
    check("mid_reset_after_state", int'(state), 0);
    dly_q.delete();
    stray_q.delete();
    dl = {1}; sl = {0};
    run_batch(1, 1'b0);

    // Randomised batches.
    for (int b = 0; b < 12; b++) begin
      int n;
      int r;
      n = $urandom_range(0, 6);
      dl = {};
      sl = {};
      for (int k = 0; k < n; k++) begin
        r = $urandom_range(0, 9);
        if (r < 6)       dl.push_back($urandom_range(1, 4));
        else if (r == 6) dl.push_back(TIMEOUT);
        else if (r == 7) dl.push_back(0);
        else             dl.push_back($urandom_range(1, 8));
        sl.push_back(1'($urandom_range(0, 1)));
      end
      run_batch(n, 1'($urandom_range(0, 1)));
    end

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish by cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
